// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM requester ports, shared memory port and stall/err outputs of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_dm;
  logic              err;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_dm, err
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_dm, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: MEM-priority arbiter serialising IF and MEM stage accesses onto one memory port.
// Define ARB_TIMEOUT_EN to add a busy-cycle watchdog that aborts the access and pulses err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;
  state_t state, state_n;
  logic busy, finish, timeout;
  logic mem_req, mem_we, if_ack, dm_ack, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, if_rdata, dm_rdata;
  assign busy   = state == IF_BUSY || state == DM_BUSY;
  assign finish = busy && (bus.mem_ready || timeout);
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;
  assign timeout = busy && !bus.mem_ready && cnt == CNT_W'(TIMEOUT - 1);
  // counter sits at zero in IDLE, so every grant starts a fresh window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : busy ? cnt + 1'b1 : cnt;
      err <= timeout;
    end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.dm_req ? DM_BUSY : bus.if_req ? IF_BUSY : IDLE)
            : state == DONE ? IDLE
            : finish        ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      if_ack <= finish && state == IF_BUSY;
      dm_ack <= finish && state == DM_BUSY;
      if (state == IDLE && (bus.dm_req || bus.if_req)) begin
        mem_req  <= 1'b1;
        mem_we   <= bus.dm_req && bus.dm_we;
        mem_addr <= bus.dm_req ? bus.dm_addr : bus.if_addr;
        if (bus.dm_req) mem_wdata <= bus.dm_wdata;
      end
      if (finish) mem_req <= 1'b0;
      if (finish && state == IF_BUSY) if_rdata <= timeout ? '0 : bus.mem_rdata;
      // stores leave the load data register untouched
      if (finish && state == DM_BUSY && !mem_we) dm_rdata <= timeout ? '0 : bus.mem_rdata;
    end
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.if_ack    = if_ack;
  assign bus.dm_ack    = dm_ack;
  assign bus.err       = err;
  assign bus.stall_if  = bus.if_req & ~if_ack;
  assign bus.stall_dm  = bus.dm_req & ~dm_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomised checks of the arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TO   = 4;
  localparam int MAXD = TO - 1;
`else
  localparam int TO   = 255;
  localparam int MAXD = 5;
`endif
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} xact_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc++;
  bit resp_en = 1'b1, noise = 1'b0, timed_out = 1'b0;
  int ready_delay = 0, wcnt = 0;
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_if = '0, exp_dm = '0;
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  // memory behaviour: answers ready_delay cycles after it first sees mem_req
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_req || !resp_en) begin
        wcnt = 0;
        bus.mem_ready = noise && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end else if (wcnt == ready_delay) begin
        wcnt = 0;
        bus.mem_ready = 1'b1;
        if (bus.mem_we) begin
          resp_mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = $urandom;
        end else
          bus.mem_rdata = resp_mem.exists(bus.mem_addr) ? resp_mem[bus.mem_addr] : init_word(bus.mem_addr);
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end
    end
  end
  xact_t log_q[$];
  xact_t exp_q[$];
  xact_t prev_x = '0;
  logic prev_req = 1'b0;
  int grants, unstable, err_n, err_cyc, if_ack_n, dm_ack_n, if_ack_cyc, dm_ack_cyc, stall_bad;
  always @(negedge clk) begin
    if (bus.mem_req && prev_req && prev_x != {bus.mem_we, bus.mem_addr, bus.mem_wdata}) unstable++;
    if (bus.mem_req && !prev_req) grants++;
    if (bus.mem_req && bus.mem_ready) log_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
    if (bus.err) begin err_n++; err_cyc = cyc - t0; end
    if (bus.if_ack) begin if_ack_n++; if_ack_cyc = cyc - t0; end
    if (bus.dm_ack) begin dm_ack_n++; dm_ack_cyc = cyc - t0; end
    if (bus.stall_if !== (bus.if_req && !bus.if_ack) || bus.stall_dm !== (bus.dm_req && !bus.dm_ack)) stall_bad++;
    prev_req = bus.mem_req;
    prev_x = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
  end
  // raises the requests in cycle 0 and drops each one the cycle after its ack
  task automatic issue(input bit do_if, input bit do_dm, input bit we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input int d);
    ready_delay = d;
    @(posedge clk); #1;
    t0 = cyc;
    grants = 0; unstable = 0; err_n = 0; err_cyc = -1; stall_bad = 0;
    if_ack_n = 0; dm_ack_n = 0; if_ack_cyc = -1; dm_ack_cyc = -1;
    log_q.delete();
    bus.if_req = do_if; bus.if_addr = ia;
    bus.dm_req = do_dm; bus.dm_we = we; bus.dm_addr = da; bus.dm_wdata = wd;
    for (int i = 0; i < 200 && (bus.if_req || bus.dm_req); i++) begin
      @(posedge clk); #1;
      if (if_ack_n != 0 && bus.if_req) begin bus.if_req = 1'b0; bus.if_addr = $urandom; end
      if (dm_ack_n != 0 && bus.dm_req) begin bus.dm_req = 1'b0; bus.dm_addr = $urandom; bus.dm_wdata = $urandom; end
    end
    timed_out = bus.if_req || bus.dm_req;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
    bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.err, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: mem_req=%b mem_addr=%h if_rdata=%h dm_rdata=%h want all 0", bus.mem_req, bus.mem_addr, bus.if_rdata, bus.dm_rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resp_en = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h1000_0040; bus.dm_wdata = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1000_0040) begin
      errors++;
      $display("FAIL busy_before_reset: mem_req=%b mem_addr=%h want 1 10000040", bus.mem_req, bus.mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.err, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== '0) begin
      errors++;
      $display("FAIL mid_access_reset: mem_req=%b mem_we=%b mem_addr=%h mem_wdata=%h want all 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.dm_ack !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: mem_req=%b dm_ack=%b want 0 0", bus.mem_req, bus.dm_ack);
    end
  endtask
  task automatic test_lone_fetch();
    ref_mem[32'h0040_0000] = 32'h8C08_0004;
    resp_mem[32'h0040_0000] = 32'h8C08_0004;
    issue(1'b1, 1'b0, 1'b0, 32'h0040_0000, '0, '0, 1);
    exp_if = 32'h8C08_0004;
    checks++;
    if (timed_out || if_ack_cyc != 3 || if_ack_n != 1) begin
      errors++;
      $display("FAIL fetch_latency: ack_cycle=%0d acks=%0d stuck=%0d want 3 1 0", if_ack_cyc, if_ack_n, timed_out);
    end
    checks++;
    if (bus.if_rdata !== exp_if) begin
      errors++;
      $display("FAIL fetch_rdata: got %h want %h", bus.if_rdata, exp_if);
    end
    checks++;
    if (stall_bad != 0 || grants != 1 || log_q.size() != 1 || log_q[0] !== xact_t'({1'b0, 32'h0040_0000, 32'h0}) && log_q[0].addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL fetch_bus: stall_errs=%0d grants=%0d xacts=%0d want 0 1 1", stall_bad, grants, log_q.size());
    end
  endtask
  task automatic test_simultaneous();
    logic [31:0] ia;
    ia = 32'h0040_0000 + {$urandom_range(1, 63), 2'b00};
    issue(1'b1, 1'b1, 1'b0, ia, 32'h1000_0010, '0, 0);
    exp_dm = ref_read(32'h1000_0010);
    exp_if = ref_read(ia);
    checks++;
    if (timed_out || dm_ack_cyc != 2 || if_ack_cyc != 5 || dm_ack_n != 1 || if_ack_n != 1) begin
      errors++;
      $display("FAIL simul_order: dm_ack=%0d if_ack=%0d counts=%0d/%0d want 2 5 1/1", dm_ack_cyc, if_ack_cyc, dm_ack_n, if_ack_n);
    end
    checks++;
    if (log_q.size() != 2 || log_q[0].addr !== 32'h1000_0010 || log_q[1].addr !== ia || log_q[0].we !== 1'b0 || log_q[1].we !== 1'b0) begin
      errors++;
      $display("FAIL simul_bus: xacts=%0d first=%h want 2 first addr 10000010 then %h", log_q.size(), log_q.size() > 0 ? log_q[0].addr : 32'h0, ia);
    end
    checks++;
    if (bus.dm_rdata !== exp_dm || bus.if_rdata !== exp_if || stall_bad != 0) begin
      errors++;
      $display("FAIL simul_rdata: dm=%h if=%h stall_errs=%0d want %h %h 0", bus.dm_rdata, bus.if_rdata, stall_bad, exp_dm, exp_if);
    end
  endtask
  task automatic test_store();
    issue(1'b0, 1'b1, 1'b1, '0, 32'h1000_0020, 32'hDEAD_BEEF, 1);
    ref_mem[32'h1000_0020] = 32'hDEAD_BEEF;
    checks++;
    if (log_q.size() != 1 || log_q[0] !== xact_t'({1'b1, 32'h1000_0020, 32'hDEAD_BEEF})) begin
      errors++;
      $display("FAIL store_bus: xacts=%0d first=%h want 1 1_10000020_deadbeef", log_q.size(), log_q.size() > 0 ? log_q[0] : xact_t'(0));
    end
    checks++;
    if (timed_out || dm_ack_n != 1 || dm_ack_cyc != 3 || bus.dm_rdata !== exp_dm) begin
      errors++;
      $display("FAIL store_ack: acks=%0d cycle=%0d dm_rdata=%h want 1 3 %h", dm_ack_n, dm_ack_cyc, bus.dm_rdata, exp_dm);
    end
    issue(1'b0, 1'b1, 1'b0, '0, 32'h1000_0020, '0, 0);
    exp_dm = ref_read(32'h1000_0020);
    checks++;
    if (bus.dm_rdata !== exp_dm) begin
      errors++;
      $display("FAIL store_readback: got %h want %h", bus.dm_rdata, exp_dm);
    end
  endtask
  task automatic test_slow_memory();
    issue(1'b0, 1'b1, 1'b0, '0, 32'h1000_0064, '0, MAXD);
    exp_dm = ref_read(32'h1000_0064);
    checks++;
    if (timed_out || dm_ack_n != 1 || dm_ack_cyc != 2 + MAXD || grants != 1 || unstable != 0) begin
      errors++;
      $display("FAIL slow_mem: acks=%0d cycle=%0d grants=%0d unstable=%0d want 1 %0d 1 0", dm_ack_n, dm_ack_cyc, grants, unstable, 2 + MAXD);
    end
    checks++;
    if (bus.dm_rdata !== exp_dm || err_n != 0) begin
      errors++;
      $display("FAIL slow_rdata: got %h err=%0d want %h 0", bus.dm_rdata, err_n, exp_dm);
    end
  endtask
  task automatic test_random();
    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit do_if, do_dm, we;
      int d, first, second;
      logic [31:0] ia, da, wd;
      bit ok;
      do_if = $urandom_range(0, 1);
      do_dm = !do_if || $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 1);
      ia = 32'h1000_0000 + {$urandom_range(0, 7), 2'b00};
      da = 32'h1000_0000 + {$urandom_range(0, 7), 2'b00};
      wd = $urandom;
      d = $urandom_range(0, MAXD);
      exp_q.delete();
      if (do_dm) begin
        exp_q.push_back({we, da, we ? wd : 32'h0});
        if (we) ref_mem[da] = wd;
        else exp_dm = ref_read(da);
      end
      if (do_if) begin
        exp_q.push_back({1'b0, ia, 32'h0});
        exp_if = ref_read(ia);
      end
      first = 2 + d;
      second = first + 3 + d;
      issue(do_if, do_dm, we, ia, da, wd, d);
      checks++;
      if (timed_out || (do_dm && (dm_ack_n != 1 || dm_ack_cyc != first)) || (do_if && (if_ack_n != 1 || if_ack_cyc != (do_dm ? second : first)))
          || (!do_dm && dm_ack_n != 0) || (!do_if && if_ack_n != 0)) begin
        errors++;
        $display("FAIL rand_ack[%0d]: dm %0d@%0d if %0d@%0d want dm %0d@%0d if %0d@%0d", n, dm_ack_n, dm_ack_cyc, if_ack_n, if_ack_cyc,
                 do_dm, first, do_if, do_dm ? second : first);
      end
      ok = log_q.size() == exp_q.size();
      for (int i = 0; ok && i < exp_q.size(); i++)
        ok = log_q[i].we === exp_q[i].we && log_q[i].addr === exp_q[i].addr && (!exp_q[i].we || log_q[i].wdata === exp_q[i].wdata);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_bus[%0d]: xacts=%0d first=%h want %0d first=%h", n, log_q.size(), log_q.size() > 0 ? log_q[0] : xact_t'(0),
                 exp_q.size(), exp_q[0]);
      end
      checks++;
      if (bus.dm_rdata !== exp_dm || bus.if_rdata !== exp_if) begin
        errors++;
        $display("FAIL rand_rdata[%0d]: dm=%h if=%h want %h %h", n, bus.dm_rdata, bus.if_rdata, exp_dm, exp_if);
      end
      checks++;
      if (stall_bad != 0 || err_n != 0 || unstable != 0 || grants != exp_q.size()) begin
        errors++;
        $display("FAIL rand_misc[%0d]: stall_errs=%0d err=%0d unstable=%0d grants=%0d want 0 0 0 %0d", n, stall_bad, err_n, unstable, grants, exp_q.size());
      end
    end
    noise = 1'b0;
  endtask
`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    resp_en = 1'b0;
    issue(1'b0, 1'b1, 1'b0, '0, 32'h1000_0030, '0, 0);
    resp_en = 1'b1;
    exp_dm = '0;
    checks++;
    if (timed_out || dm_ack_n != 1 || dm_ack_cyc != TO + 1 || err_n != 1 || err_cyc != dm_ack_cyc) begin
      errors++;
      $display("FAIL timeout_pulse: ack %0d@%0d err %0d@%0d want 1@%0d 1@%0d", dm_ack_n, dm_ack_cyc, err_n, err_cyc, TO + 1, TO + 1);
    end
    checks++;
    if (bus.dm_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: dm_rdata=%h mem_req=%b want 0 0", bus.dm_rdata, bus.mem_req);
    end
    issue(1'b1, 1'b0, 1'b0, 32'h0040_0000, '0, '0, 1);
    checks++;
    if (if_ack_cyc != 3 || bus.if_rdata !== ref_read(32'h0040_0000)) begin
      errors++;
      $display("FAIL timeout_recover: ack_cycle=%0d if_rdata=%h want 3 %h", if_ack_cyc, bus.if_rdata, ref_read(32'h0040_0000));
    end
  endtask
`endif
  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store();
    test_slow_memory();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-ported unified memory shared by the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined MIPS core. It serialises the two requesters onto one memory port with a request/ready handshake, latches read data, and produces per-stage stall signals so the pipeline freezes while an access is outstanding. The MEM stage has priority because it holds the older instruction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ack  out  1  one-cycle completion pulse to IF
- dm_req  in  1  data request (MemRead | MemWrite from MEM stage); held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ack  out  1  one-cycle completion pulse to MEM
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory completion, sampled while mem_req high
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_dm  out  1  dm_req & ~dm_ack (combinational)
- err  out  1  one-cycle timeout pulse; constant 0 without ARB_TIMEOUT_EN

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE: dm_req -> DM_BUSY, capture dm_we/dm_addr/dm_wdata into mem_*; else if_req -> IF_BUSY, capture if_addr, mem_we=0; else stay.
- Both requests in IDLE: DM wins; IF waits, stall_if remains high.
- *_BUSY: mem_req=1, mem_* frozen; on mem_ready -> DONE, drop mem_req, latch mem_rdata into if_rdata (IF_BUSY) or dm_rdata (DM_BUSY load); store leaves dm_rdata unchanged.
- DONE: exactly one of if_ack/dm_ack high; -> IDLE unconditionally. Requester deasserts req at the edge ending DONE; IDLE then sees the next request, so no double service.
- if_rdata/dm_rdata hold their last value until overwritten.
- Requests changing while not granted are sampled only in IDLE.

## Timing
- Reset (async): state IDLE; mem_req, mem_we, if_ack, dm_ack, err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0. In-flight transaction abandoned; mem_req drops immediately.
- Latency, req in cycle 0 with idle arbiter: mem_req high from cycle 1; mem_ready seen in cycle k (k>=1) -> ack high in cycle k+1; best case ack in cycle 2.
- Back-to-back: DONE->IDLE costs one cycle; next grant earliest 1 cycle after ack, mem_req 2 cycles after ack.
- mem_ready outside *_BUSY ignored.
- stall_* combinational from req and ack; no added latency.

## Configuration
- ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on grant, increments each *_BUSY cycle without mem_ready; reaching TIMEOUT -> DONE with ack plus err pulse, rdata for that access forced to 0, mem_req dropped.
- Not defined: no counter; *_BUSY waits indefinitely for mem_ready; err tied 0.

## Test plan
- Reset mid-access: assert rst while DM_BUSY -> mem_req=0 same cycle, all outputs 0, state IDLE after release.
- Lone fetch: if_req, if_addr=0x0040_0000, mem_ready 1 cycle after mem_req with mem_rdata=0x8C08_0004 -> if_ack in cycle 3, if_rdata=0x8C08_0004, stall_if low from then.
- Simultaneous: if_req and dm_req (load 0x1000_0010) in same IDLE cycle -> DM served first, dm_ack then IF granted; stall_if high throughout DM access.
- Store: dm_we=1, dm_addr=0x1000_0020, dm_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF; dm_ack pulses; dm_rdata unchanged.
- Slow memory: mem_ready delayed 5 cycles -> mem_* stable for all 5 cycles, single ack pulse, no re-issue.
- With ARB_TIMEOUT_EN, TIMEOUT=4, mem_ready never asserted -> err and dm_ack pulse together after 4 busy cycles, dm_rdata=0, return to IDLE.
